// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source IDs and the round-robin pick used by the CDB arbiter.
package cdb_arbiter_pkg;

  localparam int TagBus     = 4;
  localparam int DataBus    = 32;
  localparam int AddressBus = 32;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_BR  = 2'd2
  } src_e;

  typedef struct packed {
    logic vld;
    src_e src;
  } grant_t;

  // First candidate found scanning ALU -> LSB -> BR, starting just after last.
  function automatic grant_t rr_pick(input logic [2:0] cand, input src_e last);
    grant_t     g;
    logic [1:0] idx;
    g.vld = 1'b0;
    g.src = SRC_ALU;
    idx   = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!g.vld && cand[idx]) begin
        g.vld = 1'b1;
        g.src = src_e'(idx);
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result FIFO: push/pop/flush, registered count and head; 0-cycle head read.
// No internal overflow guard; the arbiter only pushes when count != DEPTH and pops when non-empty.
module cdb_src_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head_dat
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter (ALU/LSB/BR FIFOs -> one registered bus); latency 2, or 1 with CDB_BYPASS_EN.
// Backpressure: x_ready from rdy, clear and registered FIFO count; rdy low freezes all state.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DataBus,
  parameter int TAG_W      = TagBus,
  parameter int ADDR_W     = AddressBus,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [TAG_W-1:0]  lsb_tag,
  input  logic [DATA_W-1:0] lsb_data,
  output logic              lsb_ready,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  input  logic              br_jump,
  input  logic [ADDR_W-1:0] br_pc,
  output logic              br_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_jump,
  output logic [ADDR_W-1:0] cdb_pc,
  output logic [1:0]        cdb_src
);

  localparam int            CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } res_t;

  typedef struct packed {
    logic              jump;
    logic [ADDR_W-1:0] pc;
    res_t              res;
  } br_res_t;

  logic [CW-1:0] alu_cnt, lsb_cnt, br_cnt;
  res_t          alu_in, lsb_in, alu_head, lsb_head;
  br_res_t       br_in, br_head, win;
  logic [2:0]    acc, fifo_nz, byp, cand, sel, push, pop;
  logic          flush, take;
  grant_t        gnt;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              cdb_jump_q, cdb_jump_d;
  logic [ADDR_W-1:0] cdb_pc_q, cdb_pc_d;
  logic [1:0]        cdb_src_q, cdb_src_d;
  src_e              last_grant_q, last_grant_d;

  assign alu_in = {alu_tag, alu_data};
  assign lsb_in = {lsb_tag, lsb_data};
  assign br_in  = {br_jump, br_pc, br_tag, br_data};

  assign alu_ready = rdy && !clear && (alu_cnt != FULL);
  assign lsb_ready = rdy && !clear && (lsb_cnt != FULL);
  assign br_ready  = rdy && !clear && (br_cnt != FULL);

  assign acc     = {br_valid && br_ready, lsb_valid && lsb_ready, alu_valid && alu_ready};
  assign fifo_nz = {br_cnt != '0, lsb_cnt != '0, alu_cnt != '0};
  // clear is only honoured while the ROB itself is advancing
  assign flush   = rdy && clear;

`ifdef CDB_BYPASS_EN
  // Only an empty FIFO may be bypassed, so per-source order is preserved.
  assign byp = acc & ~fifo_nz;
`else
  assign byp = 3'b000;
`endif

  assign cand = fifo_nz | byp;
  assign gnt  = rr_pick(cand, last_grant_q);
  assign take = rdy && !clear && gnt.vld;
  assign sel  = take ? (3'b001 << gnt.src) : 3'b000;
  assign push = acc & ~(sel & byp);
  assign pop  = sel & ~byp;

  always_comb begin
    win = '0;
    case (gnt.src)
      SRC_ALU: win.res = byp[0] ? alu_in : alu_head;
      SRC_LSB: win.res = byp[1] ? lsb_in : lsb_head;
      default: win     = byp[2] ? br_in : br_head;
    endcase
  end

  cdb_src_fifo #(.W($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push[0]),
    .push_dat (alu_in),
    .pop      (pop[0]),
    .flush    (flush),
    .count    (alu_cnt),
    .head_dat (alu_head)
  );

  cdb_src_fifo #(.W($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push[1]),
    .push_dat (lsb_in),
    .pop      (pop[1]),
    .flush    (flush),
    .count    (lsb_cnt),
    .head_dat (lsb_head)
  );

  cdb_src_fifo #(.W($bits(br_res_t)), .DEPTH(FIFO_DEPTH)) u_br_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push[2]),
    .push_dat (br_in),
    .pop      (pop[2]),
    .flush    (flush),
    .count    (br_cnt),
    .head_dat (br_head)
  );

  always_comb begin
    cdb_valid_d  = cdb_valid_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_data_d   = cdb_data_q;
    cdb_jump_d   = cdb_jump_q;
    cdb_pc_d     = cdb_pc_q;
    cdb_src_d    = cdb_src_q;
    last_grant_d = last_grant_q;
    if (rdy) begin
      cdb_valid_d = 1'b0;
      if (take) begin
        cdb_valid_d  = 1'b1;
        cdb_tag_d    = win.res.tag;
        cdb_data_d   = win.res.data;
        cdb_jump_d   = win.jump;
        cdb_pc_d     = win.pc;
        cdb_src_d    = gnt.src;
        last_grant_d = gnt.src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
      cdb_jump_q   <= 1'b0;
      cdb_pc_q     <= '0;
      cdb_src_q    <= '0;
      last_grant_q <= SRC_BR;
    end else begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      cdb_jump_q   <= cdb_jump_d;
      cdb_pc_q     <= cdb_pc_d;
      cdb_src_q    <= cdb_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_jump  = cdb_jump_q;
  assign cdb_pc    = cdb_pc_q;
  assign cdb_src   = cdb_src_q;

endmodule
